lsu_ctrl: RTL and testbench

Load/store sequencer between the execute stage and a data memory on a req/gnt/rvalid bus. It replaces the single-cycle dm_en strobe from the control unit. The block stalls the core for the whole access and generates byte enables and store-data lane replication. It also aligns and extends load data, and reports misaligned, illegal-size and bus-timeout faults. It sits beside the ALU: the ALU supplies the effective address and the control unit supplies the request.

---
 rtl/lsu_pkg.sv | 87 ++++++++
 rtl/lsu_align.sv | 21 ++
 rtl/lsu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store sequencer.
// Sizes follow the RV32 funct3 encoding of loads and stores.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  function automatic logic [3:0] gen_be_f(
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    case (funct3)
      LSU_B, LSU_BU: return 4'b0001 << addr_lo;
      LSU_H, LSU_HU: return 4'b0011 << addr_lo;
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] align_wdata_f(
    input logic [2:0]  funct3,
    input logic [31:0] wdata
  );
    case (funct3)
      LSU_B, LSU_BU: return {4{wdata[7:0]}};
      LSU_H, LSU_HU: return {2{wdata[15:0]}};
      default:       return wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract_rdata_f(
    input logic [2:0]  funct3,
    input logic [1:0]  addr_lo,
    input logic [31:0] rdata
  );
    logic [31:0] sh;
    sh = rdata >> {addr_lo, 3'b000};
    case (funct3)
      LSU_B:   return {{24{sh[7]}}, sh[7:0]};
      LSU_BU:  return {24'b0, sh[7:0]};
      LSU_H:   return {{16{sh[15]}}, sh[15:0]};
      LSU_HU:  return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic misaligned_f(
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    case (funct3)
      LSU_H, LSU_HU: return addr_lo[0];
      LSU_W:         return addr_lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  // Stores have no unsigned forms.
  function automatic logic illegal_f(
    input logic       we,
    input logic [2:0] funct3
  );
    case (funct3)
      LSU_B, LSU_H, LSU_W: return 1'b0;
      LSU_BU, LSU_HU:      return we;
      default:             return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: enables, store replication, load extraction.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  assign be         = gen_be_f(funct3, addr_lo);
  assign wdata_al   = align_wdata_f(funct3, wdata);
  assign rdata_ext  = extract_rdata_f(funct3, addr_lo, rdata);
  assign misaligned = misaligned_f(funct3, addr_lo);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between EX and a req/gnt/rvalid data bus.
// Stalls the core for the access and reports alignment/bus faults.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            flush,
  output logic            stall,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            err,
  output logic [1:0]      err_cause,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t      state_q, state_d;
  lsu_err_t        cause_q, cause_d;
  logic            kill_q, kill_d;
  logic            latch, capture;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      lo_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [3:0]      be_q;
  logic [CW-1:0]   cnt_q;
  logic            tmo_hit, ill, mis;

  logic [2:0]      al_f3;
  logic [1:0]      al_lo;
  logic [3:0]      al_be;
  logic [31:0]     al_wdata, al_rdata;

  // Steer the incoming request in IDLE, the latched access afterwards.
  assign al_f3 = (state_q == S_IDLE) ? req_funct3 : f3_q;
  assign al_lo = (state_q == S_IDLE) ? req_addr[1:0] : lo_q;

  lsu_align u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata_al   (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (mis)
  );

  assign ill     = illegal_f(req_we, req_funct3);
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    kill_d  = kill_q;
    latch   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          unique case (1'b1)
            ill: begin
              state_d = S_ERR;
              cause_d = ERR_ILLEGAL;
            end
            !ill && mis: begin
              state_d = S_ERR;
              cause_d = ERR_MISALIGN;
            end
            !ill && !mis: begin
              state_d = S_REQ;
              kill_d  = 1'b0;
              latch   = 1'b1;
            end
          endcase
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = S_WAIT;
          kill_d  = flush;
        end else if (flush) begin
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          cause_d = ERR_TIMEOUT;
        end
      end
      S_WAIT: begin
        kill_d = kill_q | flush;
        if (mem_rvalid) begin
          state_d = S_DONE;
          capture = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          cause_d = ERR_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= ERR_NONE;
      kill_q  <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      cause_q <= cause_d;
      kill_q  <= kill_d;
      if (latch) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        lo_q    <= req_addr[1:0];
        addr_q  <= {req_addr[XLEN-1:2], 2'b00};
        be_q    <= al_be;
        wdata_q <= al_wdata;
        cnt_q   <= '0;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (capture) rdata_q <= we_q ? '0 : al_rdata;
    end
  end

  assign stall = (state_q == S_IDLE && req_valid && !flush)
               || state_q == S_REQ || state_q == S_WAIT;

  assign rsp_valid = (state_q == S_DONE) && !kill_q;
  assign rsp_rdata = rdata_q;
  assign err       = (state_q == S_ERR);
  assign err_cause = (state_q == S_ERR) ? cause_q : ERR_NONE;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl with a transaction-level model.
// Per-cycle expectations are compared on the falling edge.
module tb_lsu_ctrl;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, flush;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, err, mem_req, mem_gnt, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  err_cause;
  logic [3:0]  mem_be;
  logic        mem_rvalid;

  lsu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .flush      (flush),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err        (err),
    .err_cause  (err_cause),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cnt, req_cnt;
  logic chk_en = 1'b0;

  logic        e_stall, e_req, e_rsp, e_err, e_we;
  logic        e_bus, e_rdchk, e_cchk;
  logic [1:0]  e_cause;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_rdata;

  logic [31:0] last_addr, last_wdata, last_rdata;
  logic [3:0]  last_be;
  logic [1:0]  last_cause;
  logic        last_we;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("err", 32'(err), 32'(e_err));
      if (stall) stall_cnt++;
      if (mem_req) req_cnt++;
      if (e_bus) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        last_addr = mem_addr;
        last_be = mem_be;
        last_wdata = mem_wdata;
        last_we = mem_we;
      end
      if (e_rdchk) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        last_rdata = rsp_rdata;
      end
      if (e_cchk) begin
        chk("err_cause", 32'(err_cause), 32'(e_cause));
        if (e_err) last_cause = err_cause;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---- behavioural model ----
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 == F_B || f3 == F_H || f3 == F_W);
    return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [1:0] lo);
    return (int'(lo) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [1:0] lo);
    int m;
    m = ((1 << m_size(f3)) - 1) << lo;
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3,
                                          input logic [1:0] lo,
                                          input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = m_size(f3);
    v = rd >> (8 * lo);
    if (sz < 4) begin
      mask = (32'h1 << (8 * sz)) - 1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---- drivers ----
  task automatic cyc();
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    flush = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_rsp = 1'b0; e_err = 1'b0;
    e_bus = 1'b0; e_rdchk = 1'b0; e_cchk = 1'b0;
  endtask

  task automatic exp_reset();
    e_bus = 1'b1; e_addr = '0; e_be = '0; e_wdata = '0; e_we = 1'b0;
    e_rdchk = 1'b1; e_rdata = '0;
    e_cchk = 1'b1; e_cause = 2'b00;
  endtask

  task automatic stray();
    mem_gnt = 1'($urandom_range(0, 1));
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  task automatic err_tail(input logic [1:0] cause);
    cyc();
    req_valid = 1'b0;
    stray();
    e_err = 1'b1; e_cchk = 1'b1; e_cause = cause;
    cyc();
    stray();
  endtask

  // fm: 0 none, 1 flush in first REQ cycle, 2 flush in first WAIT cycle
  task automatic access(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int gd, input int rdl,
                        input int fm);
    logic ill, mis, killed;
    int t;
    ill = m_illegal(we, f3);
    mis = !ill && m_mis(f3, addr[1:0]);
    if (fm == 1 && gd == 0) fm = 0;
    if (fm == 2 && gd + rdl >= 12) fm = 0;
    cyc();
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd;
    e_stall = 1'b1;
    if (ill || mis) begin
      err_tail(ill ? 2'b11 : 2'b01);
      return;
    end
    killed = 1'b0;
    t = 0;
    for (int k = 0; ; k++) begin
      cyc();
      e_stall = 1'b1; e_req = 1'b1; e_bus = 1'b1;
      e_addr = addr & 32'hFFFF_FFFC;
      e_be = m_be(f3, addr[1:0]);
      e_wdata = m_wdata(f3, wd);
      e_we = we;
      if (fm == 1) begin
        flush = 1'b1;
        cyc();
        req_valid = 1'b0;
        return;
      end
      if (k == gd) begin
        mem_gnt = 1'b1;
        t++;
        break;
      end
      if (t == TMO - 1) begin
        err_tail(2'b10);
        return;
      end
      t++;
    end
    for (int k = 0; ; k++) begin
      cyc();
      e_stall = 1'b1;
      if (fm == 2 && k == 0) begin
        flush = 1'b1;
        killed = 1'b1;
      end
      if (k == rdl) begin
        mem_rvalid = 1'b1;
        mem_rdata = rd;
        break;
      end
      mem_rdata = $urandom;
      if (t == TMO - 1) begin
        err_tail(2'b10);
        return;
      end
      t++;
    end
    cyc();
    stray();
    e_rsp = !killed;
    e_rdchk = !killed;
    e_rdata = we ? 32'h0 : m_rdata(f3, addr[1:0], rd);
    cyc();
    req_valid = 1'b0;
    stray();
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    logic w;
    int r, gd, rdl, fm;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    stall_cnt = 0; req_cnt = 0;
    @(posedge clk);
    #1;
    cyc();
    exp_reset();
    chk_en = 1'b1;
    cyc();
    exp_reset();
    rst_n = 1'b1;

    stall_cnt = 0;
    access(1'b0, F_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0);
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);
    chk("lw_be", 32'(last_be), 32'hF);
    chk("lw_addr", last_addr, 32'h100);

    access(1'b0, F_B, 32'h203, 32'h0, 32'h80AABBCC, 1, 0, 0);
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    chk("lb_be", 32'(last_be), 32'h8);
    access(1'b0, F_BU, 32'h203, 32'h0, 32'h80AABBCC, 0, 2, 0);
    chk("lbu_rdata", last_rdata, 32'h00000080);
    access(1'b0, F_H, 32'h202, 32'h0, 32'h80AABBCC, 0, 0, 0);
    chk("lh_rdata", last_rdata, 32'hFFFF80AA);

    access(1'b1, F_H, 32'h12, 32'h0000BEEF, 32'h0, 2, 1, 0);
    chk("sh_addr", last_addr, 32'h10);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hBEEFBEEF);
    chk("sh_we", 32'(last_we), 32'h1);

    req_cnt = 0;
    access(1'b0, F_W, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    chk("lw_mis_cause", 32'(last_cause), 32'h1);
    access(1'b1, F_H, 32'h13, 32'h0, 32'h0, 0, 0, 0);
    chk("sh_mis_cause", 32'(last_cause), 32'h1);
    access(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 0, 0, 0);
    chk("ld_ill_cause", 32'(last_cause), 32'h3);
    chk("fault_no_req", 32'(req_cnt), 32'd0);

    req_cnt = 0;
    access(1'b0, F_W, 32'h80, 32'h0, 32'h0, 100, 0, 0);
    chk("tmo_req_cycles", 32'(req_cnt), 32'd16);
    chk("tmo_cause", 32'(last_cause), 32'h2);

    access(1'b0, F_W, 32'h84, 32'h0, 32'h1234, 2, 1, 1);
    access(1'b0, F_W, 32'h88, 32'h0, 32'h5678, 1, 2, 2);

    // request coincident with flush is dropped
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W;
    req_addr = 32'h90; flush = 1'b1;
    cyc();
    req_valid = 1'b0;

    // reset in the middle of WAIT
    cyc();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W;
    req_addr = 32'hA0; req_wdata = 32'hCAFEF00D;
    e_stall = 1'b1;
    cyc();
    e_stall = 1'b1; e_req = 1'b1; mem_gnt = 1'b1;
    cyc();
    e_stall = 1'b1;
    cyc();
    req_valid = 1'b0;
    rst_n = 1'b0;
    exp_reset();
    cyc();
    rst_n = 1'b1;
    exp_reset();

    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 4);
        f3 = (r == 0) ? F_B : (r == 1) ? F_H : (r == 2) ? F_W :
             (r == 3) ? F_BU : F_HU;
      end
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      r = $urandom_range(0, 19);
      gd = (r < 16) ? r % 4 : (r == 19) ? 30 : $urandom_range(4, 14);
      r = $urandom_range(0, 19);
      rdl = (r < 16) ? r % 4 : (r == 19) ? 30 : $urandom_range(4, 14);
      r = $urandom_range(0, 9);
      fm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      access(w, f3, a, $urandom, $urandom, gd, rdl, fm);
    end

    cyc();
    cyc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
